rgb_pixel_fifo: RTL

Elastic buffer for classified RGB pixels. It sits between the combinational skin-classification stage and the pixel-to-byte serialiser that feeds the UART transmitter. The classifier emits one-cycle pixel strobes faster than the paced UART path can drain them. This block stores whole 24-bit pixels, presents them first-word-fall-through, and flags any pixel lost to overflow.

---
 rtl/rgb_pixel_fifo.sv | 81 ++++++++
 1 files changed

// File: rtl/rgb_pixel_fifo.sv
// First-word-fall-through elastic buffer for 24-bit classified RGB pixels.
// Drops pushes while full (unless a pop frees a slot) and flags the loss in a sticky overflow bit.
module rgb_pixel_fifo #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              data_in_valid,
  input  logic [7:0]        r_data_in,
  input  logic [7:0]        g_data_in,
  input  logic [7:0]        b_data_in,
  input  logic              data_out_ack,
  input  logic              ovf_clr,
  output logic [7:0]        r_data_out,
  output logic [7:0]        g_data_out,
  output logic [7:0]        b_data_out,
  output logic              data_out_valid,
  output logic              full,
  output logic [ADDR_W:0]   level,
  output logic              overflow
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [23:0]       r_mem [2**ADDR_W];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_level;
  logic              r_overflow;
  logic [23:0]       r_last;

  logic        w_empty;
  logic        w_full;
  logic        w_pop;
  logic        w_push;
  logic        w_drop;
  logic [23:0] w_head;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == DEPTH);
  assign w_pop   = data_out_ack && !w_empty;
  assign w_push  = data_in_valid && (!w_full || w_pop);
  assign w_drop  = data_in_valid && w_full && !w_pop;
  assign w_head  = r_mem[r_rd_ptr];

  always_ff @(posedge sys_clk) begin
    if (!sys_rst && w_push) begin
      r_mem[r_wr_ptr] <= {r_data_in, g_data_in, b_data_in};
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
      r_last     <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      // A dropped push outranks a clear in the same cycle.
      if (w_drop)       r_overflow <= 1'b1;
      else if (ovf_clr) r_overflow <= 1'b0;
      // Remember the displayed head so the outputs hold once the FIFO drains.
      if (!w_empty) r_last <= w_head;
    end
  end

  assign {r_data_out, g_data_out, b_data_out} = w_empty ? r_last : w_head;
  assign data_out_valid = !w_empty;
  assign full           = w_full;
  assign level          = r_level;
  assign overflow       = r_overflow;

endmodule
